// File: rtl/conv_stream_tx.sv
// Source-side streamer for the conv engine: host-loaded kernel and image tile,
// streamed kernel-first on valid/ready. Optional zero border: CONV_TX_PAD_EN.
module conv_stream_tx #(
  parameter int bitwidth      = 16,
  parameter int img_width     = 4,
  parameter int img_height    = 4,
  parameter int weight_width  = 2,
  parameter int weight_height = 2,
  parameter int padding       = 1,
  parameter int addr_w        = 8
) (
  input  logic                clk_en,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic                wr_sel,
  input  logic [addr_w-1:0]   wr_addr,
  input  logic [bitwidth-1:0] wr_data,
  input  logic [bitwidth-1:0] bias_in,
  input  logic                start,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [bitwidth-1:0] out_data,
  output logic                out_is_weight,
  output logic                out_last,
  output logic [bitwidth-1:0] b0,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  // Handshake: a beat transfers on every rising edge where out_valid && out_ready;
  // once raised, out_valid and the presented word hold until that transfer.

`ifdef CONV_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int PAD = PAD_EN ? padding : 0;
  localparam int NW  = weight_width * weight_height;
  localparam int NI  = img_width * img_height;
  localparam int PW  = img_width + 2 * PAD;
  localparam int PH  = img_height + 2 * PAD;
  localparam int KW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int IAW = (NI > 1) ? $clog2(NI) : 1;
  localparam int CW  = (PW > 1) ? $clog2(PW) : 1;
  localparam int RW  = (PH > 1) ? $clog2(PH) : 1;

  typedef enum logic [1:0] {IDLE, SEND_W, SEND_IMG, FIN} state_t;

  state_t              state, state_nxt;
  logic [bitwidth-1:0] ibuf [NI];
  logic [bitwidth-1:0] wbuf [NW];
  logic [KW-1:0]       k;
  logic [RW-1:0]       row, nxt_row;
  logic [CW-1:0]       col, nxt_col;
  logic [IAW-1:0]      pix_idx;
  logic [bitwidth-1:0] pix_word, w0_fwd;
  logic                pix_inside, fire, last_w, last_img;

  assign fire     = out_valid && out_ready;
  assign last_w   = (k == KW'(NW - 1));
  assign last_img = (row == RW'(PH - 1)) && (col == CW'(PW - 1));
  // A weight[0] write in the start cycle must reach the first beat.
  assign w0_fwd   = (wr_en && wr_sel && (wr_addr == '0)) ? wr_data : wbuf[0];

  // Host buffers are not reset; writes only land while idle and in range.
  always_ff @(posedge clk_en) begin
    if (state == IDLE && wr_en) begin
      if (!wr_sel && (int'(wr_addr) < NI)) ibuf[wr_addr[IAW-1:0]] <= wr_data;
      if (wr_sel && (int'(wr_addr) < NW))  wbuf[wr_addr[KW-1:0]]  <= wr_data;
    end
  end

  // Next image position to present; the first pixel follows the last weight.
  always_comb begin
    nxt_row = row;
    nxt_col = col;
    if (state == SEND_W) begin
      nxt_row = '0;
      nxt_col = '0;
    end else if (col == CW'(PW - 1)) begin
      nxt_row = row + RW'(1);
      nxt_col = '0;
    end else begin
      nxt_col = col + CW'(1);
    end
    pix_inside = (int'(nxt_row) >= PAD) && (int'(nxt_row) < PAD + img_height) &&
                 (int'(nxt_col) >= PAD) && (int'(nxt_col) < PAD + img_width);
    pix_idx = '0;
    if (pix_inside)
      pix_idx = IAW'((int'(nxt_row) - PAD) * img_width + (int'(nxt_col) - PAD));
    pix_word = pix_inside ? ibuf[pix_idx] : '0;
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SEND_W;
      SEND_W:   if (fire && last_w) state_nxt = SEND_IMG;
      SEND_IMG: if (fire && last_img) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid     = (state == SEND_W) || (state == SEND_IMG);
    out_is_weight = (state == SEND_W);
    out_last      = (state == SEND_IMG) && last_img;
    busy          = out_valid;
    done          = (state == FIN);
    state_dbg     = state;
  end

  always_ff @(posedge clk_en) begin
    if (!rst_n) begin
      k        <= '0;
      row      <= '0;
      col      <= '0;
      out_data <= '0;
      b0       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          b0       <= bias_in;
          k        <= '0;
          row      <= '0;
          col      <= '0;
          out_data <= w0_fwd;
        end
        SEND_W: if (fire) begin
          if (last_w) begin
            out_data <= pix_word;
          end else begin
            k        <= k + KW'(1);
            out_data <= wbuf[k + KW'(1)];
          end
        end
        SEND_IMG: if (fire && !last_img) begin
          row      <= nxt_row;
          col      <= nxt_col;
          out_data <= pix_word;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_tx.sv
// Directed-sequence bench for conv_stream_tx: a behavioural model of host buffers
// builds each expected stream; beats are checked against the expected queue.
module tb_conv_stream_tx;

  localparam int BW = 16, IW = 4, IH = 4, WW = 2, WH = 2, PADP = 1, AW = 8;
  localparam int NI = IW * IH, NW = WW * WH;
`ifdef CONV_TX_PAD_EN
  localparam int PD = PADP;
`else
  localparam int PD = 0;
`endif
  localparam int PW = IW + 2 * PD, PH = IH + 2 * PD;

  logic          clk_en = 1'b0;
  logic          rst_n, wr_en, wr_sel, start, out_ready;
  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data, bias_in;
  logic          out_valid, out_is_weight, out_last, busy, done;
  logic [BW-1:0] out_data, b0;
  logic [1:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] img_m [NI];
  logic [BW-1:0] w_m [NW];
  logic [BW+1:0] exp_q[$];
  bit            seen77;

  conv_stream_tx #(
    .bitwidth(BW), .img_width(IW), .img_height(IH), .weight_width(WW),
    .weight_height(WH), .padding(PADP), .addr_w(AW)
  ) dut (
    .clk_en(clk_en), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .bias_in(bias_in), .start(start),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_is_weight(out_is_weight), .out_last(out_last), .b0(b0), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  always #5 clk_en = ~clk_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_en);
    #1;
  endtask

  task automatic do_write(input bit sel, input int addr, input logic [BW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = data;
    if (!sel && addr < NI) img_m[addr] = data;
    if (sel && addr < NW)  w_m[addr]   = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic build_expected();
    int r_i, c_i;
    logic [BW-1:0] v;
    exp_q.delete();
    for (int i = 0; i < NW; i++) exp_q.push_back({1'b1, 1'b0, w_m[i]});
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        r_i = r - PD; c_i = c - PD;
        v = (r_i < 0 || r_i >= IH || c_i < 0 || c_i >= IW) ? '0 : img_m[r_i * IW + c_i];
        exp_q.push_back({1'b0, (r == PH - 1) && (c == PW - 1), v});
      end
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'(($urandom_range(0, 1)));
  endfunction

  task automatic run_stream(input int mode, input logic [BW-1:0] bias, input int abort_at,
                            input bit meddle, input bit fwd_w0);
    int beats = 0, cyc = 0, n_words;
    bit held_v = 0, meddled = 0, poked = 0;
    logic [BW+1:0] held, got, expw;
    if (fwd_w0) begin
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = BW'($urandom);
      w_m[0] = wr_data;
    end
    build_expected();
    n_words = exp_q.size();
    bias_in = bias; start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0; bias_in = BW'($urandom);
    chk("first_valid", out_valid, 1'b1);
    chk("busy_on", busy, 1'b1);
    while (exp_q.size() > 0 && cyc < 2000) begin
      got = {out_is_weight, out_last, out_data};
      if (held_v) begin
        chk("stall_hold", got, held);
        held_v = 0;
      end
      if (abort_at > 0 && beats == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        exp_q.delete();
        return;
      end
      out_ready = pick_ready(mode, cyc);
      if (!out_valid) begin
        chk("valid_drop", out_valid, 1'b1);
      end else if (out_ready) begin
        expw = exp_q.pop_front();
        chk("beat", got, expw);
        chk("b0_stable", b0, bias);
        if (out_data == 16'd77) seen77 = 1;
        beats++;
      end else begin
        held = got; held_v = 1;
      end
      if (meddle && beats == 7 && !meddled) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 16'd99;
        meddled = 1; poked = 1;
      end
      tick();
      if (poked) begin start = 1'b0; wr_en = 1'b0; poked = 0; end
      cyc++;
    end
    chk("timeout", exp_q.size(), 0);
    chk("beat_count", beats, n_words);
    chk("done_pulse", done, 1'b1);
    chk("fin_valid", out_valid, 1'b0);
    chk("fin_busy", busy, 1'b0);
    chk("fin_last", out_last, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_once", {done, busy}, 2'b00);
    end
    chk("b0_hold", b0, bias);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    bias_in = '0; start = 1'b0; out_ready = 1'b0; seen77 = 0;
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'd0);
    chk("rst_isw", out_is_weight, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_b0", b0, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NW; i++) do_write(1'b1, i, BW'(i + 1));
    for (int i = 0; i < NI; i++) do_write(1'b0, i, BW'(i + 1));

    run_stream(0, 16'd5, 0, 0, 0);
    run_stream(1, 16'd5, 0, 0, 0);
    run_stream(0, 16'h1234, 0, 1, 0);
    run_stream(2, 16'd7, 0, 0, 0);

    run_stream(0, 16'd9, 7, 0, 0);
    chk("abort_b0", b0, 16'd0);
    run_stream(2, 16'd3, 0, 0, 0);

    seen77 = 0;
    do_write(1'b0, 16, 16'd77);
    do_write(1'b0, 15, 16'd42);
    run_stream(0, 16'd11, 0, 0, 0);
    chk("no_77", seen77, 1'b0);

    run_stream(0, 16'd21, 0, 0, 1);

    for (int i = 0; i < NI; i++) do_write(1'b0, i, BW'($urandom));
    for (int i = 0; i < NW; i++) do_write(1'b1, i, BW'($urandom));
    run_stream(2, BW'($urandom), 0, 0, 0);
    run_stream(1, BW'($urandom), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
